depar_merge_segs: RTL
=====================

Name: depar_merge_segs

Overview:
- Deparser output-side re-assembler.
- Takes per-packet first-half and second-half bundles (2 segments each) from the half FIFOs, plus the remaining-segment FIFO, and re-serialises them into one AXI4-Stream packet.
- Inverse of the deparser's segment splitter. Sits between the deparser's half/remaining FIFOs and the pipeline output port.
- Every packet has exactly one fst_half entry and one snd_half entry. Remaining-FIFO entries exist only for packets longer than 4 segments.

Parameters:
- C_AXIS_DATA_WIDTH, 256, segment data width.
- C_AXIS_TUSER_WIDTH, 128, per-segment tuser width.
- C_NUM_SEGS, 4, segments held across both halves; each half holds C_NUM_SEGS/2.

Ports:
- clk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- fst_half_tdata  in  DW*2  segment 0 at [0+:DW], segment 1 at [DW+:DW]. Same packing applies to tuser/tkeep/tlast.
- fst_half_tuser  in  UW*2  per-segment tuser.
- fst_half_tkeep  in  DW/8*2  per-segment tkeep.
- fst_half_tlast  in  2  per-segment tlast.
- fst_half_empty  in  1  first-half FIFO empty.
- fst_half_rd_en  out  1  pop first-half FIFO.
- snd_half_tdata/tuser/tkeep/tlast  in  DW*2 / UW*2 / DW/8*2 / 2  segments 2,3; same packing.
- snd_half_empty  in  1  second-half FIFO empty.
- snd_half_rd_en  out  1  pop second-half FIFO.
- seg_fifo_tdata  in  DW  remaining segment.
- seg_fifo_tuser  in  UW  remaining segment tuser.
- seg_fifo_tkeep  in  DW/8  remaining segment tkeep.
- seg_fifo_tlast  in  1  remaining segment tlast.
- seg_fifo_empty  in  1  remaining FIFO empty.
- seg_fifo_rd_en  out  1  pop remaining FIFO.
- m_axis_tdata  out  DW  output data.
- m_axis_tuser  out  UW  output tuser.
- m_axis_tkeep  out  DW/8  output tkeep.
- m_axis_tlast  out  1  output tlast.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

Behaviour:
- Single clock clk; reset aresetn is synchronous, active-low.
- Reset:
  - state=IDLE.
  - All m_axis_* = 0.
  - rd_en outputs are combinational and 0 during reset.
- All input FIFOs are first-word-fall-through: data is valid whenever !empty; an rd_en pulse pops one entry.
- Output register stage:
  - Let ld = !m_axis_tvalid || m_axis_tready.
  - A segment loads into the m_axis_* registers only when ld=1.
  - Once asserted, m_axis_tvalid and data hold stable until tready.
  - When no segment loads and tready=1, tvalid clears.
- States: IDLE, SEG0, SEG1, SEG2, SEG3, FLUSH.
- IDLE:
  - Condition: !fst_half_empty && !snd_half_empty.
  - Action: go to SEG0. No output this cycle.
  - Both halves are required before starting, since the splitter always pushes both.
- SEGk (k=0..3):
  - Source segment: k<2 from fst_half index k; k>=2 from snd_half index k-2.
  - When ld: load the segment (data/tuser/tkeep/tlast).
  - If its tlast=1, or k=3: assert fst_half_rd_en and snd_half_rd_en together in that same cycle.
  - Next state: IDLE if tlast=1; FLUSH if k=3 and tlast=0; otherwise SEG(k+1).
  - Segments after tlast within a half are discarded (popped with the entry).
- FLUSH:
  - When !seg_fifo_empty && ld: load seg_fifo segment and assert seg_fifo_rd_en.
  - If seg_fifo_tlast=1, go to IDLE.
  - seg_fifo_empty: stall, no load.
- Throughput: one segment per cycle once started; 1 idle cycle between packets (IDLE decision).
- Latency: first segment appears on m_axis 2 cycles after both halves are non-empty (IDLE → SEG0 → register).
- Backpressure: with tready=0 and tvalid=1, no pops and no state change.
- Pops never occur on an empty FIFO. rd_en is never asserted while in IDLE or reset.
- Reset mid-packet:
  - Returns to IDLE, tvalid=0, no pops.
  - Upstream FIFOs are reset by the same aresetn, so no re-synchronisation is needed.

Optional Feature:
- Macro: DEPAR_MERGE_PKT_CNT_EN.
- Defined:
  - Adds output pkt_cnt (32 bits): increments when a tlast beat is accepted (tvalid&&tready&&tlast). Wraps at 2^32-1→0. Reset 0.
  - Adds output seg_err (1 bit, sticky until reset): set if fst_half_tlast[0] && fst_half_tlast[1] both 1 when SEG0 loads.
- Undefined: ports absent; no counter logic.

Test Plan:
- 1-segment packet (fst tlast=2'b01), tready=1 → one beat with fst seg0 data and tlast=1. fst_half_rd_en and snd_half_rd_en each pulse once. State back to IDLE.
- 3-segment packet (fst tlast=2'b00, snd tlast=2'b01) → 3 consecutive beats: seg0, seg1, snd seg0. tlast only on beat 3.
- 6-segment packet: halves tlast=0; seg_fifo holds 2 entries, last tlast=1 → 6 beats in order; seg_fifo_rd_en pulses twice; returns to IDLE.
- 6-segment packet with seg_fifo initially empty for 5 cycles → 4 beats, tvalid drops, then 2 beats resume. No spurious pops.
- tready toggling 1,0,0,1 on a 4-segment packet → each beat held stable while tready=0. Exactly 4 accepted beats; one pair of half pops.
- Back-to-back 2-segment packets → beats separated by exactly one idle cycle. With DEPAR_MERGE_PKT_CNT_EN, pkt_cnt=2 afterward.

Source files
------------

// File: rtl/depar_merge_segs.sv
`default_nettype none
// ============================================================================
//  Module   : depar_merge_segs
//  Purpose  : Deparser output-side re-assembler. Takes one first-half and one
//             second-half bundle per packet (two segments each), plus any
//             remaining segments, and re-serialises them into a single
//             AXI4-Stream packet on m_axis.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, aresetn              clock, synchronous active-low reset
//    fst_half_* / fst_half_empty / fst_half_rd_en
//                              FWFT first-half FIFO (segments 0,1; seg0 at
//                              the low slice of every packed field)
//    snd_half_* / snd_half_empty / snd_half_rd_en
//                              FWFT second-half FIFO (segments 2,3)
//    seg_fifo_* / seg_fifo_empty / seg_fifo_rd_en
//                              FWFT remaining-segment FIFO (segments 4..)
//    m_axis_*                  registered AXI4-Stream master output
//  Optional build macro
//    DEPAR_MERGE_PKT_CNT_EN    adds pkt_cnt (accepted packets, 32-bit wrap)
//                              and seg_err (sticky: both fst tlast bits set
//                              when segment 0 loads)
//  Note: the sequencer walks exactly two segments per half, so C_NUM_SEGS is
//  expected to be 4.
// ============================================================================
module depar_merge_segs #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 4
) (
    input  logic                                                  clk,
    input  logic                                                  aresetn,

    input  logic [C_AXIS_DATA_WIDTH*(C_NUM_SEGS/2)-1:0]           fst_half_tdata,
    input  logic [C_AXIS_TUSER_WIDTH*(C_NUM_SEGS/2)-1:0]          fst_half_tuser,
    input  logic [(C_AXIS_DATA_WIDTH/8)*(C_NUM_SEGS/2)-1:0]       fst_half_tkeep,
    input  logic [(C_NUM_SEGS/2)-1:0]                             fst_half_tlast,
    input  logic                                                  fst_half_empty,
    output logic                                                  fst_half_rd_en,

    input  logic [C_AXIS_DATA_WIDTH*(C_NUM_SEGS/2)-1:0]           snd_half_tdata,
    input  logic [C_AXIS_TUSER_WIDTH*(C_NUM_SEGS/2)-1:0]          snd_half_tuser,
    input  logic [(C_AXIS_DATA_WIDTH/8)*(C_NUM_SEGS/2)-1:0]       snd_half_tkeep,
    input  logic [(C_NUM_SEGS/2)-1:0]                             snd_half_tlast,
    input  logic                                                  snd_half_empty,
    output logic                                                  snd_half_rd_en,

    input  logic [C_AXIS_DATA_WIDTH-1:0]                          seg_fifo_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]                         seg_fifo_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]                        seg_fifo_tkeep,
    input  logic                                                  seg_fifo_tlast,
    input  logic                                                  seg_fifo_empty,
    output logic                                                  seg_fifo_rd_en,

    output logic [C_AXIS_DATA_WIDTH-1:0]                          m_axis_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                         m_axis_tuser,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]                        m_axis_tkeep,
    output logic                                                  m_axis_tlast,
    output logic                                                  m_axis_tvalid,
    input  logic                                                  m_axis_tready
`ifdef DEPAR_MERGE_PKT_CNT_EN
    ,
    output logic [31:0]                                           pkt_cnt,
    output logic                                                  seg_err
`endif
);

    localparam int c_DW = C_AXIS_DATA_WIDTH;
    localparam int c_UW = C_AXIS_TUSER_WIDTH;
    localparam int c_KW = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEG0  = 3'd1,
        ST_SEG1  = 3'd2,
        ST_SEG2  = 3'd3,
        ST_SEG3  = 3'd4,
        ST_FLUSH = 3'd5
    } state_t;

    state_t            r_state_q, w_state_d;
    logic [c_DW-1:0]   r_tdata_q, w_tdata_d;
    logic [c_UW-1:0]   r_tuser_q, w_tuser_d;
    logic [c_KW-1:0]   r_tkeep_q, w_tkeep_d;
    logic              r_tlast_q, w_tlast_d;
    logic              r_tvalid_q, w_tvalid_d;

    logic              w_ld;
    logic              w_load;
    logic              w_half_pop;
    logic              w_seg_pop;

    logic [c_DW-1:0]   w_seg_tdata;
    logic [c_UW-1:0]   w_seg_tuser;
    logic [c_KW-1:0]   w_seg_tkeep;
    logic              w_seg_tlast;

    // The output register may take a new beat when it is empty or its
    // current beat is being accepted this cycle.
    assign w_ld = !r_tvalid_q || m_axis_tready;

    // Source segment for the current state.
    always_comb begin
        w_seg_tdata = fst_half_tdata[0 +: c_DW];
        w_seg_tuser = fst_half_tuser[0 +: c_UW];
        w_seg_tkeep = fst_half_tkeep[0 +: c_KW];
        w_seg_tlast = fst_half_tlast[0];
        case (r_state_q)
            ST_SEG1: begin
                w_seg_tdata = fst_half_tdata[c_DW +: c_DW];
                w_seg_tuser = fst_half_tuser[c_UW +: c_UW];
                w_seg_tkeep = fst_half_tkeep[c_KW +: c_KW];
                w_seg_tlast = fst_half_tlast[1];
            end
            ST_SEG2: begin
                w_seg_tdata = snd_half_tdata[0 +: c_DW];
                w_seg_tuser = snd_half_tuser[0 +: c_UW];
                w_seg_tkeep = snd_half_tkeep[0 +: c_KW];
                w_seg_tlast = snd_half_tlast[0];
            end
            ST_SEG3: begin
                w_seg_tdata = snd_half_tdata[c_DW +: c_DW];
                w_seg_tuser = snd_half_tuser[c_UW +: c_UW];
                w_seg_tkeep = snd_half_tkeep[c_KW +: c_KW];
                w_seg_tlast = snd_half_tlast[1];
            end
            ST_FLUSH: begin
                w_seg_tdata = seg_fifo_tdata;
                w_seg_tuser = seg_fifo_tuser;
                w_seg_tkeep = seg_fifo_tkeep;
                w_seg_tlast = seg_fifo_tlast;
            end
            default: ;
        endcase
    end

    // Next-state and output-register logic.
    always_comb begin
        w_state_d  = r_state_q;
        w_load     = 1'b0;
        w_half_pop = 1'b0;
        w_seg_pop  = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                // The splitter always pushes both halves, so wait for both.
                if (!fst_half_empty && !snd_half_empty) begin
                    w_state_d = ST_SEG0;
                end
            end
            ST_SEG0, ST_SEG1, ST_SEG2, ST_SEG3: begin
                if (w_ld) begin
                    w_load = 1'b1;
                    // Both halves retire together; any segments after tlast
                    // inside a half are dropped with the entry.
                    if (w_seg_tlast || (r_state_q == ST_SEG3)) begin
                        w_half_pop = 1'b1;
                    end
                    if (w_seg_tlast) begin
                        w_state_d = ST_IDLE;
                    end else if (r_state_q == ST_SEG3) begin
                        w_state_d = ST_FLUSH;
                    end else begin
                        w_state_d = state_t'(r_state_q + 3'd1);
                    end
                end
            end
            ST_FLUSH: begin
                if (!seg_fifo_empty && w_ld) begin
                    w_load    = 1'b1;
                    w_seg_pop = 1'b1;
                    if (seg_fifo_tlast) begin
                        w_state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Hold the beat until accepted; drop valid once taken with no refill.
        w_tvalid_d = r_tvalid_q && !m_axis_tready;
        w_tdata_d  = r_tdata_q;
        w_tuser_d  = r_tuser_q;
        w_tkeep_d  = r_tkeep_q;
        w_tlast_d  = r_tlast_q;
        if (w_load) begin
            w_tvalid_d = 1'b1;
            w_tdata_d  = w_seg_tdata;
            w_tuser_d  = w_seg_tuser;
            w_tkeep_d  = w_seg_tkeep;
            w_tlast_d  = w_seg_tlast;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state_q  <= ST_IDLE;
            r_tvalid_q <= 1'b0;
            r_tdata_q  <= '0;
            r_tuser_q  <= '0;
            r_tkeep_q  <= '0;
            r_tlast_q  <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_tvalid_q <= w_tvalid_d;
            r_tdata_q  <= w_tdata_d;
            r_tuser_q  <= w_tuser_d;
            r_tkeep_q  <= w_tkeep_d;
            r_tlast_q  <= w_tlast_d;
        end
    end

    // Pops are combinational and forced low while reset is held.
    assign fst_half_rd_en = w_half_pop && aresetn;
    assign snd_half_rd_en = w_half_pop && aresetn;
    assign seg_fifo_rd_en = w_seg_pop  && aresetn;

    assign m_axis_tdata  = r_tdata_q;
    assign m_axis_tuser  = r_tuser_q;
    assign m_axis_tkeep  = r_tkeep_q;
    assign m_axis_tlast  = r_tlast_q;
    assign m_axis_tvalid = r_tvalid_q;

`ifdef DEPAR_MERGE_PKT_CNT_EN
    logic [31:0] r_pkt_cnt_q, w_pkt_cnt_d;
    logic        r_seg_err_q, w_seg_err_d;

    always_comb begin
        w_pkt_cnt_d = r_pkt_cnt_q;
        w_seg_err_d = r_seg_err_q;
        if (r_tvalid_q && m_axis_tready && r_tlast_q) begin
            w_pkt_cnt_d = r_pkt_cnt_q + 32'd1;
        end
        if ((r_state_q == ST_SEG0) && w_load && (fst_half_tlast[1:0] == 2'b11)) begin
            w_seg_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_pkt_cnt_q <= 32'd0;
            r_seg_err_q <= 1'b0;
        end else begin
            r_pkt_cnt_q <= w_pkt_cnt_d;
            r_seg_err_q <= w_seg_err_d;
        end
    end

    assign pkt_cnt = r_pkt_cnt_q;
    assign seg_err = r_seg_err_q;
`endif

endmodule
`default_nettype wire
